screenmem_arbiter: RTL
======================

Name: screenmem_arbiter

Overview:
Owns the single-port synchronous screen RAM (80x24 chars, 7-bit, VT52 address map). It shares the RAM between two users:
- the video generator's character fetch, which has fixed, guaranteed slots;
- the terminal engine's host port (writes, plus optional reads).

It also contains an erase engine that fills a span of one text row with a blank character, used for clear-line, clear-screen and scroll. It sits between the terminal logic, the video generator and the RAM.

Parameters:
ADDR_W, 11, physical screen RAM address width
DATA_W, 7, character width
ERASE_CHAR, 7'h20, character written by the erase engine
MAX_X, 79, last valid column

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
vid_slot  in  1  high = current cycle belongs to video (video clock phase)
vid_addr  in  ADDR_W  video fetch address, sampled in vid_slot cycles
vid_data  out  DATA_W  last character fetched for video
host_req  in  1  host access request, held until acked
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  physical address
host_wdata  in  DATA_W  write data
host_ack  out  1  request served this cycle
host_rdata  out  DATA_W  read data (feature-dependent)
host_rvalid  out  1  host_rdata valid
erase_start  in  1  single-cycle erase command
erase_y  in  5  row 0..23
erase_x0  in  7  first column
erase_x1  in  7  last column, inclusive
erase_busy  out  1  erase in progress
erase_done  out  1  one-cycle completion pulse
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after the address

Behaviour:
- Reset values: vid_data=0, host_ack=0, host_rdata=0, host_rvalid=0, erase_busy=0, erase_done=0, mem_we=0.
- Reset asserted mid-erase aborts the erase immediately. No done pulse is produced.
- Video slot (vid_slot=1):
  - mem_addr=vid_addr, mem_we=0. Absolute priority; never stalled.
  - vid_data is loaded from mem_rdata at the edge ending the cycle after the slot; it holds otherwise.
  - Net latency: vid_data is valid 2 edges after the slot cycle.
- Terminal slot (vid_slot=0), priority order:
  1. Erase engine, while in state ERASE.
  2. Host: if host_req, then mem_addr=host_addr, mem_we=host_we, mem_wdata=host_wdata, and host_ack=1 (combinational, this cycle only).
  3. Otherwise idle: mem_we=0.
- host_ack is never high in vid_slot cycles or while erase_busy. Host must hold req/addr/data until it sees ack.
- Erase FSM has states IDLE and ERASE.
  - IDLE: erase_start with erase_x0<=erase_x1<=MAX_X and erase_y<=23 latches y and x1, sets cur_x=x0, goes to ERASE, and asserts erase_busy from the next cycle.
  - IDLE, invalid command: no writes, erase_done pulses on the next cycle.
  - ERASE: each terminal slot writes ERASE_CHAR to map(cur_x,y).
  - If cur_x==x1, go to IDLE and pulse erase_done in the following cycle. Otherwise increment cur_x.
  - erase_start while busy is ignored.
  - A host request pending at erase_start waits until erase completes.
- Address map: map(X,Y)
  - = {Y[0],2'b11,Y[2:1],Y[4:3],X[3:0]} when X[6] or (Y[4]&Y[3]);
  - = {Y[0],Y[4:1],X[5:0]} otherwise.
- Erase write count is always x1-x0+1. Column 64 crossing needs no special case beyond the map.

Optional Feature:
SCREENMEM_RDBACK_EN
- Defined: a host read (host_we=0) is acked. host_rdata is loaded from mem_rdata one cycle after ack, and host_rvalid pulses for one cycle.
- Undefined: host_rdata and host_rvalid are tied to 0. Reads are still acked, for protocol uniformity, but return nothing.

Decomposition:
- Package screenmem_pkg holds ADDR_W, DATA_W, ERASE_CHAR, ROWS=24, COLS=80, the FSM state enum, and a map function implementing the VT52 mapping.
- One sub-module, screenmem_erase_engine: contains the FSM, cur_x counter and done pulse, and outputs a write request, address and busy.
- The top level does slot and priority muxing and the video/host data registers.

Test Plan:
- Video read: RAM[0x123]=0x41, vid_addr=0x123, vid_slot alternating -> vid_data=0x41 two edges after the slot; no mem_we in video slots.
- Host write: host_req, we=1, addr=0x005, data=0x5A raised in a vid_slot=1 cycle -> ack low; ack high in the next slot-0 cycle with mem_we=1, RAM[0x005]=0x5A.
- Erase span: y=2, x0=60, x1=70 -> 11 writes of 0x20:
  - 0x07C..0x07F for X=60..63;
  - 0x340..0x346 for X=64..70;
  - busy for 11 terminal slots, then one erase_done pulse; host_req held throughout is acked only afterwards.
- Invalid and busy: erase_start with x0=10, x1=5 -> no writes, done next cycle; erase_start during busy -> ignored, write count unchanged.
- Reset mid-erase: reset after 3 writes -> erase_busy=0 and no further writes asynchronously; erase_done never pulses.
- RDBACK (macro defined): after erase, host read 0x07C -> ack, then host_rvalid with host_rdata=0x20 next cycle. Undefined -> ack only, rvalid stays 0.

Source files
------------

// File: rtl/screenmem_pkg.sv
// Shared constants, erase FSM state type and the VT52 (X,Y) -> physical screen RAM address map.
package screenmem_pkg;

  localparam int          ADDR_W     = 11;
  localparam int          DATA_W     = 7;
  localparam logic [6:0]  ERASE_CHAR = 7'h20;
  localparam int          ROWS       = 24;
  localparam int          COLS       = 80;
  localparam logic [6:0]  MAX_X      = 7'(COLS - 1);
  localparam logic [4:0]  MAX_Y      = 5'(ROWS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ERASE = 1'b1
  } erase_state_e;

  // Columns 64..79 and rows 24..31 fold into the holes left by the 64-wide rows.
  function automatic logic [ADDR_W-1:0] map_xy(input logic [6:0] x, input logic [4:0] y);
    if (x[6] || (y[4] && y[3]))
      map_xy = {y[0], 2'b11, y[2:1], y[4:3], x[3:0]};
    else
      map_xy = {y[0], y[4:1], x[5:0]};
  endfunction

endpackage

// File: rtl/screenmem_erase_engine.sv
// Row-span erase engine: fills columns x0..x1 of one text row with the blank character,
// one write per terminal slot.
module screenmem_erase_engine
  import screenmem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vid_slot,
  input  logic              i_start,
  input  logic [4:0]        i_y,
  input  logic [6:0]        i_x0,
  input  logic [6:0]        i_x1,
  output logic              o_wr_req,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_busy,
  output logic              o_hold,
  output logic              o_done
);

  erase_state_e r_state;
  logic         r_done;
  logic [4:0]   r_y;
  logic [6:0]   r_x1;
  logic [6:0]   r_cur_x;
  logic         w_cmd_ok;
  logic         w_accept;
  logic         w_last;

  assign w_cmd_ok  = (i_x0 <= i_x1) && (i_x1 <= MAX_X) && (i_y <= MAX_Y);
  assign w_accept  = (r_state == IDLE) && i_start && w_cmd_ok;
  assign w_last    = (r_cur_x == r_x1);

  assign o_busy    = (r_state == ERASE);
  assign o_wr_req  = o_busy && !i_vid_slot;
  assign o_wr_addr = map_xy(r_cur_x, r_y);
  // A host request present when an erase is accepted must not slip in ahead of it.
  assign o_hold    = o_busy || w_accept;
  assign o_done    = r_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (w_cmd_ok) r_state <= ERASE;
            else          r_done  <= 1'b1;
          end
        end
        ERASE: begin
          if (o_wr_req && w_last) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_y     <= i_y;
      r_x1    <= i_x1;
      r_cur_x <= i_x0;
    end else if (o_wr_req && !w_last) begin
      r_cur_x <= r_cur_x + 7'd1;
    end
  end

endmodule

// File: rtl/screenmem_arbiter.sv
// Screen RAM arbiter: video fetch owns vid_slot cycles; terminal slots go to the erase
// engine first, then the host port. Define SCREENMEM_RDBACK_EN to return host read data.
module screenmem_arbiter
  import screenmem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              vid_slot,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              erase_start,
  input  logic [4:0]        erase_y,
  input  logic [6:0]        erase_x0,
  input  logic [6:0]        erase_x1,
  output logic              erase_busy,
  output logic              erase_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              w_er_wr;
  logic [ADDR_W-1:0] w_er_addr;
  logic              w_er_hold;
  logic              r_vid_pend;

  screenmem_erase_engine u_erase (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_vid_slot (vid_slot),
    .i_start    (erase_start),
    .i_y        (erase_y),
    .i_x0       (erase_x0),
    .i_x1       (erase_x1),
    .o_wr_req   (w_er_wr),
    .o_wr_addr  (w_er_addr),
    .o_busy     (erase_busy),
    .o_hold     (w_er_hold),
    .o_done     (erase_done)
  );

  always_comb begin
    mem_addr  = host_addr;
    mem_we    = 1'b0;
    mem_wdata = host_wdata;
    host_ack  = 1'b0;
    if (vid_slot) begin
      mem_addr = vid_addr;
    end else if (w_er_wr) begin
      mem_addr  = w_er_addr;
      mem_we    = 1'b1;
      mem_wdata = ERASE_CHAR;
    end else if (host_req && !w_er_hold) begin
      mem_addr = host_addr;
      mem_we   = host_we;
      host_ack = 1'b1;
    end
  end

  // RAM read data lands one cycle after the address; capture it on the following edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vid_pend <= 1'b0;
      vid_data   <= '0;
    end else begin
      r_vid_pend <= vid_slot;
      if (r_vid_pend) vid_data <= mem_rdata;
    end
  end

`ifdef SCREENMEM_RDBACK_EN
  logic              r_rd_pend;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_pend <= 1'b0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rd_pend <= host_ack && !host_we;
      r_rvalid  <= r_rd_pend;
      if (r_rd_pend) r_rdata <= mem_rdata;
    end
  end

  assign host_rdata  = r_rdata;
  assign host_rvalid = r_rvalid;
`else
  assign host_rdata  = '0;
  assign host_rvalid = 1'b0;
`endif

endmodule
